// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the three-port SDRAM request arbiter.
package sdram_arb_pkg;

  localparam int unsigned ADDR_W           = 23;
  localparam int unsigned BLANK_CYCLES_DEF = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  typedef enum logic [1:0] {
    LD  = 2'd0,
    CPU = 2'd1,
    VID = 2'd2
  } arb_port_t;

endpackage

// File: rtl/sdram_arb.sv
// Three-port arbiter (loader / CPU / video) in front of the SDRAM controller.
// Turns level-held client requests into single rd/we strobes, waits for the
// controller's ready, returns read data and pulses a one-cycle ack.
module sdram_arb
  import sdram_arb_pkg::*;
#(
  parameter int unsigned BLANK_CYCLES = BLANK_CYCLES_DEF,
  parameter bit          RR_EN        = 1'b1
) (
  input  logic              clk,
  input  logic              init,

  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [7:0]        ld_din,
  output logic              ld_ack,

  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_din,
  output logic [7:0]        cpu_dout,
  output logic              cpu_ack,

  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [15:0]       vid_dout,
  output logic              vid_ack,

  output logic [ADDR_W-1:0] sd_addr,
  output logic [15:0]       sd_din,
  output logic [1:0]        sd_wtbt,
  output logic              sd_we,
  output logic              sd_rd,
  input  logic [15:0]       sd_dout,
  input  logic              sd_ready
);

  // Counter is loaded with BLANK_CYCLES-1 so that ready is first accepted
  // exactly BLANK_CYCLES edges after the strobe rises.
  localparam int unsigned       CNT_W      = (BLANK_CYCLES > 2) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);

  arb_state_t        state_q;
  arb_port_t         port_q;
  arb_port_t         grant;
  logic              write_q;
  logic              vid_first_q;
  logic [CNT_W-1:0]  blank_q;
  logic [2:0]        req_eff;
  logic              any_req;

  // Fixed loader priority, then CPU/video in the order given by the RR pointer.
  function automatic arb_port_t pick_port(input logic [2:0] req, input logic vid_first);
    arb_port_t p;
    if (req[0])
      p = LD;
    else if (vid_first)
      p = req[2] ? VID : CPU;
    else
      p = req[1] ? CPU : VID;
    return p;
  endfunction

  // A port whose ack is high this cycle still holds req legally; mask it so
  // the same request is not served twice.
  always_comb begin
    req_eff = {vid_req & ~vid_ack, cpu_req & ~cpu_ack, ld_req & ~ld_ack};
    any_req = |req_eff;
    grant   = pick_port(req_eff, vid_first_q);
  end

  // Access sequencer: grant, strobe, blanking/ready wait, ack.
  always_ff @(posedge clk) begin
    if (init) begin
      state_q     <= IDLE;
      port_q      <= LD;
      write_q     <= 1'b0;
      vid_first_q <= 1'b0;
      blank_q     <= '0;
      sd_we       <= 1'b0;
      sd_rd       <= 1'b0;
      sd_addr     <= '0;
      sd_din      <= '0;
      sd_wtbt     <= '0;
      cpu_dout    <= '0;
      vid_dout    <= '0;
      ld_ack      <= 1'b0;
      cpu_ack     <= 1'b0;
      vid_ack     <= 1'b0;
    end else begin
      ld_ack  <= 1'b0;
      cpu_ack <= 1'b0;
      vid_ack <= 1'b0;
      case (state_q)
        IDLE: begin
          if (sd_ready && any_req) begin
            port_q  <= grant;
            sd_wtbt <= '0;
            state_q <= ISSUE;
            case (grant)
              LD: begin
                sd_addr <= ld_addr;
                sd_din  <= {8'h00, ld_din};
                write_q <= 1'b1;
              end
              CPU: begin
                sd_addr <= cpu_addr;
                sd_din  <= {8'h00, cpu_din};
                write_q <= cpu_we;
              end
              default: begin
                sd_addr <= vid_addr;
                sd_din  <= '0;
                write_q <= 1'b0;
              end
            endcase
            if (RR_EN && (grant != LD))
              vid_first_q <= ~vid_first_q;
          end
        end
        ISSUE: begin
          sd_we   <= write_q;
          sd_rd   <= ~write_q;
          blank_q <= BLANK_LOAD;
          state_q <= WAIT;
        end
        WAIT: begin
          if (blank_q != '0) begin
            blank_q <= blank_q - CNT_W'(1);
          end else if (sd_ready) begin
            sd_we <= 1'b0;
            sd_rd <= 1'b0;
            if (!write_q) begin
              if (port_q == CPU) cpu_dout <= sd_dout[7:0];
              if (port_q == VID) vid_dout <= sd_dout;
            end
            state_q <= DONE;
          end
        end
        DONE: begin
          ld_ack  <= (port_q == LD);
          cpu_ack <= (port_q == CPU);
          vid_ack <= (port_q == VID);
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_arb.sv
// Self-checking bench for sdram_arb: table of single accesses plus
// hand-written multi-port, reset and startup-stall sequences.
module tb_sdram_arb;

  logic        clk = 1'b0;
  logic        init = 1'b1;
  logic [2:0]  reqv = '0;
  logic        ld_req, cpu_req, vid_req;
  logic [22:0] ld_addr = '0, cpu_addr = '0, vid_addr = '0;
  logic [7:0]  ld_din = '0, cpu_din = '0;
  logic        cpu_we = 1'b0;
  logic        ld_ack, cpu_ack, vid_ack;
  logic [7:0]  cpu_dout;
  logic [15:0] vid_dout;
  logic [22:0] sd_addr;
  logic [15:0] sd_din;
  logic [1:0]  sd_wtbt;
  logic        sd_we, sd_rd;
  logic [15:0] sd_dout;
  logic        sd_ready = 1'b1;

  assign ld_req  = reqv[0];
  assign cpu_req = reqv[1];
  assign vid_req = reqv[2];

  sdram_arb #(.BLANK_CYCLES(2), .RR_EN(1'b1)) dut (
    .clk(clk), .init(init),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_din(ld_din), .ld_ack(ld_ack),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_dout(vid_dout), .vid_ack(vid_ack),
    .sd_addr(sd_addr), .sd_din(sd_din), .sd_wtbt(sd_wtbt), .sd_we(sd_we), .sd_rd(sd_rd),
    .sd_dout(sd_dout), .sd_ready(sd_ready)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Controller model: ready drops one cycle after a strobe edge, returns 8 later.
  logic [15:0] model_data = '0;
  bit          hit_mode = 1'b0;
  bit          hold_low = 1'b0;
  logic        strobe_d = 1'b0;
  int unsigned busy_cnt = 0;
  assign sd_dout = model_data;

  always @(posedge clk) begin
    strobe_d <= sd_rd | sd_we;
    if (hold_low) begin
      sd_ready <= 1'b0;
      busy_cnt <= 0;
    end else if ((sd_rd | sd_we) && !strobe_d && !hit_mode) begin
      sd_ready <= 1'b0;
      busy_cnt <= 8;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1) sd_ready <= 1'b1;
    end else begin
      sd_ready <= 1'b1;
    end
  end

  // Strobe monitor: rising edges, bus snapshot at each rise, shortest low gap.
  logic        mon_prev = 1'b0;
  int unsigned rises = 0;
  int unsigned low_run = 1000;
  int unsigned min_gap = 1000;
  logic [22:0] rise_addr = '0;
  logic [15:0] rise_din = '0;
  logic [1:0]  rise_wtbt = '0;
  logic        rise_we = 1'b0;

  always @(negedge clk) begin
    mon_prev <= sd_rd | sd_we;
    if ((sd_rd | sd_we) && !mon_prev) begin
      rises     <= rises + 1;
      rise_addr <= sd_addr;
      rise_din  <= sd_din;
      rise_wtbt <= sd_wtbt;
      rise_we   <= sd_we;
      if (low_run < min_gap) min_gap <= low_run;
    end
    low_run <= (sd_rd | sd_we) ? 0 : low_run + 1;
  end

  int unsigned errors = 0;
  int unsigned checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  typedef struct {
    int unsigned port;
    logic [15:0] data;
  } sb_t;
  sb_t sbq[$];

  int unsigned start_cyc = 0;
  int unsigned ack_cyc[3];

  // Client emulation: each port holds req until its ack, drops it the cycle
  // after, and re-raises it next cycle if more accesses remain.
  task automatic service(input int unsigned n0, input int unsigned n1,
                         input int unsigned n2, input int unsigned budget);
    int unsigned left[3];
    bit dropq[3];
    bit raiseq[3];
    logic [2:0] acks;
    int unsigned t;
    bit busy;
    sb_t e;
    left[0] = n0; left[1] = n1; left[2] = n2;
    @(negedge clk);
    for (int p = 0; p < 3; p++) begin
      dropq[p] = 1'b0;
      raiseq[p] = 1'b0;
      if (left[p] != 0) reqv[p] = 1'b1;
    end
    start_cyc = cyc;
    t = 0;
    busy = 1'b1;
    while (busy && t < budget) begin
      @(negedge clk);
      t++;
      for (int p = 0; p < 3; p++) begin
        if (dropq[p]) begin
          reqv[p] = 1'b0;
          dropq[p] = 1'b0;
          raiseq[p] = (left[p] != 0);
        end else if (raiseq[p]) begin
          reqv[p] = 1'b1;
          raiseq[p] = 1'b0;
        end
      end
      acks = {vid_ack, cpu_ack, ld_ack};
      for (int p = 0; p < 3; p++) begin
        if (acks[p]) begin
          ack_cyc[p] = cyc;
          check("strobe_low_at_ack", {31'd0, sd_rd | sd_we}, 32'd0);
          if (sbq.size() == 0) begin
            fail_now("unexpected_ack");
          end else begin
            e = sbq.pop_front();
            check("ack_port", p, e.port);
            if (p == 1) check("cpu_dout", {24'd0, cpu_dout}, {24'd0, e.data[7:0]});
            if (p == 2) check("vid_dout", {16'd0, vid_dout}, {16'd0, e.data});
          end
          if (left[p] != 0) left[p]--;
          dropq[p] = 1'b1;
        end
      end
      busy = (reqv != '0);
      for (int p = 0; p < 3; p++)
        if (dropq[p] || raiseq[p] || left[p] != 0) busy = 1'b1;
    end
    if (busy) begin
      fail_now("service_timeout");
      reqv = '0;
    end
  endtask

  task automatic quiet(input string name, input int unsigned n);
    int unsigned cnt;
    cnt = 0;
    repeat (n) begin
      @(negedge clk);
      if (ld_ack || cpu_ack || vid_ack) cnt++;
    end
    check(name, cnt, 0);
  endtask

  typedef struct {
    int unsigned port;
    logic        we;
    logic [22:0] addr;
    logic [7:0]  din;
    logic [15:0] mdata;
    logic        hit;
    logic [15:0] exp_data;
    int unsigned exp_lat;
  } vec_t;
  vec_t vecs[6];

  initial begin
    int unsigned r0;
    int unsigned cnt;

    vecs[0] = '{1, 1'b0, 23'h000101, 8'h77, 16'hA55A, 1'b0, 16'h005A, 13};
    vecs[1] = '{2, 1'b0, 23'h000200, 8'h00, 16'h1234, 1'b1, 16'h1234, 5};
    vecs[2] = '{1, 1'b1, 23'h00F001, 8'hC3, 16'hDEAD, 1'b0, 16'h005A, 13};
    vecs[3] = '{0, 1'b1, 23'h7FFFFE, 8'hFF, 16'h0000, 1'b1, 16'h0000, 5};
    vecs[4] = '{1, 1'b0, 23'h000003, 8'h11, 16'hBEEF, 1'b1, 16'h00EF, 5};
    vecs[5] = '{2, 1'b0, 23'h7FFFFE, 8'h00, 16'hFFFF, 1'b0, 16'hFFFF, 13};

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_acks", {29'd0, ld_ack, cpu_ack, vid_ack}, 32'd0);
    check("rst_strobes", {30'd0, sd_we, sd_rd}, 32'd0);
    check("rst_sd_addr", {9'd0, sd_addr}, 32'd0);
    check("rst_sd_din", {16'd0, sd_din}, 32'd0);
    check("rst_sd_wtbt", {30'd0, sd_wtbt}, 32'd0);
    check("rst_cpu_dout", {24'd0, cpu_dout}, 32'd0);
    check("rst_vid_dout", {16'd0, vid_dout}, 32'd0);
    init = 1'b0;
    repeat (2) @(negedge clk);

    // Single accesses from the table
    for (int i = 0; i < 6; i++) begin
      hit_mode   = vecs[i].hit;
      model_data = vecs[i].mdata;
      case (vecs[i].port)
        0: begin ld_addr = vecs[i].addr; ld_din = vecs[i].din; end
        1: begin cpu_addr = vecs[i].addr; cpu_din = vecs[i].din; cpu_we = vecs[i].we; end
        default: vid_addr = vecs[i].addr;
      endcase
      r0 = rises;
      sbq.push_back('{vecs[i].port, vecs[i].exp_data});
      service(vecs[i].port == 0, vecs[i].port == 1, vecs[i].port == 2, 200);
      check($sformatf("v%0d_latency", i), ack_cyc[vecs[i].port] - start_cyc, vecs[i].exp_lat);
      check($sformatf("v%0d_rises", i), rises - r0, 1);
      check($sformatf("v%0d_addr", i), {9'd0, rise_addr}, {9'd0, vecs[i].addr});
      check($sformatf("v%0d_wtbt", i), {30'd0, rise_wtbt}, 32'd0);
      check($sformatf("v%0d_we", i), {31'd0, rise_we}, {31'd0, vecs[i].we});
      if (vecs[i].port != 2)
        check($sformatf("v%0d_din", i), {16'd0, rise_din}, {24'd0, vecs[i].din});
      cpu_we = 1'b0;
    end

    // All three ports at once after a reset (RR pointer back to CPU)
    @(negedge clk);
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    hit_mode = 1'b0;
    model_data = 16'h6B9E;
    ld_addr = 23'h000010; ld_din = 8'h5C;
    cpu_addr = 23'h000020; cpu_we = 1'b0;
    vid_addr = 23'h000030;
    sbq.push_back('{0, 16'h0000});
    sbq.push_back('{1, 16'h009E});
    sbq.push_back('{2, 16'h6B9E});
    service(1, 1, 1, 400);

    // CPU and video contending: alternating order
    sbq.push_back('{1, 16'h009E});
    sbq.push_back('{2, 16'h6B9E});
    sbq.push_back('{1, 16'h009E});
    service(0, 2, 1, 400);
    check("min_strobe_gap_ge2", {31'd0, min_gap >= 2}, 32'd1);

    // Reset in the middle of an access
    @(negedge clk);
    model_data = 16'h0F0F;
    cpu_addr = 23'h000055;
    cpu_we = 1'b0;
    reqv[1] = 1'b1;
    for (int i = 0; i < 20 && !sd_rd; i++) @(negedge clk);
    check("rst_mid_saw_strobe", {31'd0, sd_rd}, 32'd1);
    @(negedge clk);
    init = 1'b1;
    hold_low = 1'b1;
    r0 = rises;
    @(negedge clk);
    check("rst_mid_strobe_drop", {30'd0, sd_we, sd_rd}, 32'd0);
    check("rst_mid_cpu_dout", {24'd0, cpu_dout}, 32'd0);
    check("rst_mid_vid_dout", {16'd0, vid_dout}, 32'd0);
    init = 1'b0;
    quiet("rst_mid_no_ack", 4);
    hold_low = 1'b0;
    sbq.push_back('{1, 16'h000F});
    service(0, 1, 0, 200);
    check("rst_mid_rises", rises - r0, 1);

    // Controller not ready after reset: nothing issued until ready rises
    @(negedge clk);
    init = 1'b1;
    hold_low = 1'b1;
    model_data = 16'h4321;
    cpu_addr = 23'h000102;
    reqv[1] = 1'b1;
    repeat (2) @(negedge clk);
    init = 1'b0;
    r0 = rises;
    cnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (sd_rd || sd_we || cpu_ack) cnt++;
    end
    check("stall_no_strobe", cnt, 0);
    hold_low = 1'b0;
    sbq.push_back('{1, 16'h0021});
    service(0, 1, 0, 200);
    check("stall_rises", rises - r0, 1);

    quiet("no_stray_ack", 10);
    check("scoreboard_drained", sbq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
